// File: rtl/wb_stage.sv
// Writeback stage in front of the register file. Retires ALU ops straight to
// the rf write port and runs loads through a fixed-latency data-memory read.
// It also holds the sticky overflow flag that appears as rf entry 8.
module wb_stage #(
  parameter int DW      = 8,
  parameter int AW      = 5,
  parameter int OVF_REG = 8,
  parameter int MEM_LAT = 1   // legal range 1..4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic          alu_wr_en,
  input  logic          ld_req,
  input  logic [AW-1:0] dest,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_ovf,
  input  logic          ovf_clr,
  output logic          mem_rd,
  output logic [DW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall,
  output logic          rf_we,
  output logic [AW-1:0] rf_ptr_w,
  output logic [DW-1:0] rf_di,
  output logic          r_overflow
);

  // The counter is 3 bits wide so that it can hold the largest legal latency (4).
  localparam int            CW      = 3;
  localparam logic [AW-1:0] OVF_PTR = AW'(OVF_REG);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_ISSUE = 2'd1,
    LD_WAIT  = 2'd2
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [AW-1:0]   ld_dest_reg;
  logic            mem_rd_reg;
  logic [DW-1:0]   mem_addr_reg;
  logic            stall_reg;
  logic            rf_we_reg;
  logic [AW-1:0]   rf_ptr_w_reg;
  logic [DW-1:0]   rf_di_reg;
  logic            flag_reg;
  logic            op_accept;

  // r0 is hard-wired, and pointers from OVF_REG upwards are read-only status entries.
  function automatic logic writable(input logic [AW-1:0] ptr);
    return (ptr != '0) && (ptr < OVF_PTR);
  endfunction

  // A non-load op counts only when it is taken in IDLE. While a load is in flight, upstream is stalled.
  assign op_accept = alu_valid && !ld_req && (state_reg == IDLE);

  // Load sequencer and rf write port. All outputs are registered and decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      ld_dest_reg  <= '0;
      mem_rd_reg   <= 1'b0;
      mem_addr_reg <= '0;
      stall_reg    <= 1'b0;
      rf_we_reg    <= 1'b0;
      rf_ptr_w_reg <= '0;
      rf_di_reg    <= '0;
    end else begin
      rf_we_reg  <= 1'b0;
      mem_rd_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (alu_valid) begin
            if (ld_req) begin
              ld_dest_reg  <= dest;
              mem_addr_reg <= alu_result;
              mem_rd_reg   <= 1'b1;
              stall_reg    <= 1'b1;
              state_reg    <= LD_ISSUE;
            end else if (alu_wr_en && writable(dest)) begin
              rf_we_reg    <= 1'b1;
              rf_ptr_w_reg <= dest;
              rf_di_reg    <= alu_result;
            end
          end
        end
        LD_ISSUE: begin
          cnt_reg   <= CW'(MEM_LAT);
          state_reg <= LD_WAIT;
        end
        LD_WAIT: begin
          cnt_reg <= cnt_reg - 3'd1;
          if (cnt_reg == 3'd1) begin
            // The memory data is valid in this cycle only, so capture it now.
            rf_di_reg <= mem_rdata;
            stall_reg <= 1'b0;
            state_reg <= IDLE;
            if (writable(ld_dest_reg)) begin
              rf_we_reg    <= 1'b1;
              rf_ptr_w_reg <= ld_dest_reg;
            end
          end
        end
        default: begin
          stall_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Sticky overflow flag. A set from an accepted op takes priority over a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_reg <= 1'b0;
    end else if (op_accept) begin
      flag_reg <= alu_ovf | (flag_reg & ~ovf_clr);
    end else begin
      flag_reg <= flag_reg & ~ovf_clr;
    end
  end

  assign mem_rd     = mem_rd_reg;
  assign mem_addr   = mem_addr_reg;
  assign stall      = stall_reg;
  assign rf_we      = rf_we_reg;
  assign rf_ptr_w   = rf_ptr_w_reg;
  assign rf_di      = rf_di_reg;
  assign r_overflow = flag_reg;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage. Two instances (MEM_LAT=1 and MEM_LAT=3) share the same stimulus.
// Expected rf writes are queued when an op is driven and are matched in order
// when rf_we fires.
module tb_wb_stage;
  logic       clk = 1'b0;
  logic       reset;
  logic       alu_valid, alu_wr_en, ld_req, alu_ovf, ovf_clr;
  logic [4:0] dest;
  logic [7:0] alu_result;

  logic       mem_rd1, stall1, rf_we1, ovf1;
  logic [7:0] mem_addr1, mem_rdata1, di1;
  logic [4:0] ptr1;
  logic       mem_rd3, stall3, rf_we3, ovf3;
  logic [7:0] mem_addr3, mem_rdata3, di3;
  logic [4:0] ptr3;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic [4:0] ptr;
    logic [7:0] di;
    int         cyc;
  } wr_t;
  wr_t q1[$];
  wr_t q3[$];

  typedef struct {
    logic       v, ld, wr;
    logic [4:0] dest;
    logic [7:0] res;
    logic       ovf, clr, exp_we, exp_flag;
  } vec_t;
  vec_t tbl[17];

  wb_stage #(.DW(8), .AW(5), .OVF_REG(8), .MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .alu_wr_en(alu_wr_en),
    .ld_req(ld_req), .dest(dest), .alu_result(alu_result), .alu_ovf(alu_ovf),
    .ovf_clr(ovf_clr), .mem_rd(mem_rd1), .mem_addr(mem_addr1),
    .mem_rdata(mem_rdata1), .stall(stall1), .rf_we(rf_we1), .rf_ptr_w(ptr1),
    .rf_di(di1), .r_overflow(ovf1));

  wb_stage #(.DW(8), .AW(5), .OVF_REG(8), .MEM_LAT(3)) u3 (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .alu_wr_en(alu_wr_en),
    .ld_req(ld_req), .dest(dest), .alu_result(alu_result), .alu_ovf(alu_ovf),
    .ovf_clr(ovf_clr), .mem_rd(mem_rd3), .mem_addr(mem_addr3),
    .mem_rdata(mem_rdata3), .stall(stall3), .rf_we(rf_we3), .rf_ptr_w(ptr3),
    .rf_di(di3), .r_overflow(ovf3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_fn(input logic [7:0] a);
    return a ^ 8'hD3;
  endfunction

  // Memory model: the data is valid only MEM_LAT cycles after the mem_rd cycle. At other times it reads 8'hEE.
  logic [3:0] pipe1, pipe3;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe1 <= '0;
      pipe3 <= '0;
    end else begin
      pipe1 <= {pipe1[2:0], mem_rd1};
      pipe3 <= {pipe3[2:0], mem_rd3};
    end
  end
  assign mem_rdata1 = pipe1[0] ? mem_fn(mem_addr1) : 8'hEE;
  assign mem_rdata3 = pipe3[2] ? mem_fn(mem_addr3) : 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic v, ld, wr, input logic [4:0] d,
                              input logic [7:0] r, input logic o, c, we, f);
    vec_t t;
    t.v = v; t.ld = ld; t.wr = wr; t.dest = d; t.res = r;
    t.ovf = o; t.clr = c; t.exp_we = we; t.exp_flag = f;
    return t;
  endfunction

  task automatic push_exp(input logic [4:0] p, input logic [7:0] d, input int c1, input int c3);
    wr_t e;
    e.ptr = p; e.di = d; e.cyc = c1; q1.push_back(e);
    e.cyc = c3; q3.push_back(e);
  endtask

  // Scoreboard: every rf write must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      if (rf_we1 === 1'b1) begin
        if (q1.size() == 0) check("u1 unexpected rf_we", {31'd0, rf_we1}, 0);
        else begin
          e = q1.pop_front();
          check("u1 rf_ptr_w", {27'd0, ptr1}, {27'd0, e.ptr});
          check("u1 rf_di", {24'd0, di1}, {24'd0, e.di});
          check("u1 write cycle", cyc, e.cyc);
        end
      end
      if (rf_we3 === 1'b1) begin
        if (q3.size() == 0) check("u3 unexpected rf_we", {31'd0, rf_we3}, 0);
        else begin
          e = q3.pop_front();
          check("u3 rf_ptr_w", {27'd0, ptr3}, {27'd0, e.ptr});
          check("u3 rf_di", {24'd0, di3}, {24'd0, e.di});
          check("u3 write cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Called at a negedge. Waits, within a fixed bound, until neither instance is stalling.
  task automatic wait_idle();
    int n = 0;
    while ((stall1 || stall3) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (stall1 || stall3) check("stall release timeout", {31'd0, stall1 | stall3}, 0);
  endtask

  task automatic apply(input vec_t v, input string name);
    wait_idle();
    alu_valid = v.v; ld_req = v.ld; alu_wr_en = v.wr; dest = v.dest;
    alu_result = v.res; alu_ovf = v.ovf; ovf_clr = v.clr;
    if (v.v && v.exp_we) begin
      if (v.ld) push_exp(v.dest, mem_fn(v.res), cyc + 3, cyc + 5);
      else      push_exp(v.dest, v.res, cyc + 1, cyc + 1);
    end
    @(posedge clk);
    @(negedge clk);
    alu_valid = 1'b0; ld_req = 1'b0; alu_wr_en = 1'b0; alu_ovf = 1'b0; ovf_clr = 1'b0;
    check({name, " u1 r_overflow"}, {31'd0, ovf1}, {31'd0, v.exp_flag});
    check({name, " u3 r_overflow"}, {31'd0, ovf3}, {31'd0, v.exp_flag});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          v  ld wr dest   res     ovf clr we flag
    tbl[0]  = mk(1, 0, 1, 5'd3,  8'h5A, 0, 0, 1, 0);
    tbl[1]  = mk(1, 0, 1, 5'd0,  8'h11, 1, 0, 0, 1);
    tbl[2]  = mk(1, 0, 1, 5'd8,  8'h22, 0, 1, 0, 0);
    tbl[3]  = mk(1, 0, 1, 5'd9,  8'h33, 1, 0, 0, 1);
    tbl[4]  = mk(1, 0, 0, 5'd7,  8'h77, 0, 0, 0, 1);
    tbl[5]  = mk(1, 0, 1, 5'd7,  8'h78, 1, 1, 1, 1);
    tbl[6]  = mk(0, 0, 0, 5'd0,  8'h00, 0, 1, 0, 0);
    tbl[7]  = mk(1, 1, 0, 5'd0,  8'h20, 1, 0, 0, 0);
    tbl[8]  = mk(1, 1, 1, 5'd9,  8'h30, 0, 0, 0, 0);
    tbl[9]  = mk(1, 0, 1, 5'd31, 8'h44, 0, 0, 0, 0);
    tbl[10] = mk(1, 0, 1, 5'd1,  8'hFF, 0, 0, 1, 0);
    tbl[11] = mk(1, 1, 1, 5'd7,  8'hFF, 0, 0, 1, 0);
    tbl[12] = mk(1, 0, 1, 5'd2,  8'h80, 1, 0, 1, 1);
    tbl[13] = mk(1, 1, 0, 5'd4,  8'h44, 0, 1, 1, 0);
    tbl[14] = mk(1, 0, 1, 5'd6,  8'h3C, 0, 0, 1, 0);
    tbl[15] = mk(1, 0, 1, 5'd7,  8'h01, 1, 0, 1, 1);
    tbl[16] = mk(1, 0, 0, 5'd5,  8'h02, 0, 0, 0, 1);

    reset = 1'b1; alu_valid = 0; alu_wr_en = 0; ld_req = 0; alu_ovf = 0; ovf_clr = 0;
    dest = '0; alu_result = '0;
    #3;
    check("u1 outputs in reset", {7'd0, mem_rd1, mem_addr1, stall1, rf_we1, ptr1, di1, ovf1}, 0);
    check("u3 outputs in reset", {7'd0, mem_rd3, mem_addr3, stall3, rf_we3, ptr3, di3, ovf3}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Load timing: dest 5, address 10, and memory returns C3
    alu_valid = 1; ld_req = 1; dest = 5'd5; alu_result = 8'h10;
    push_exp(5'd5, 8'hC3, cyc + 3, cyc + 5);
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      alu_valid = 0; ld_req = 0;
      check($sformatf("u1 stall c%0d", k), {31'd0, stall1}, {31'd0, k <= 2});
      check($sformatf("u3 stall c%0d", k), {31'd0, stall3}, {31'd0, k <= 4});
      check($sformatf("u1 mem_rd c%0d", k), {31'd0, mem_rd1}, {31'd0, k == 1});
      check($sformatf("u3 mem_rd c%0d", k), {31'd0, mem_rd3}, {31'd0, k == 1});
      check($sformatf("u1 rf_we c%0d", k), {31'd0, rf_we1}, {31'd0, k == 3});
      check($sformatf("u3 rf_we c%0d", k), {31'd0, rf_we3}, {31'd0, k == 5});
      if (k == 1) begin
        check("u1 mem_addr", {24'd0, mem_addr1}, 32'h10);
        check("u3 mem_addr", {24'd0, mem_addr3}, 32'h10);
      end
    end

    for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a load aborts it in both instances
    apply(mk(1, 0, 1, 5'd2, 8'h66, 1, 0, 1, 1), "pre-reset op");
    alu_valid = 1; ld_req = 1; dest = 5'd6; alu_result = 8'h40;
    @(posedge clk);
    #1 alu_valid = 0; ld_req = 0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("u1 outputs after async reset", {7'd0, mem_rd1, mem_addr1, stall1, rf_we1, ptr1, di1, ovf1}, 0);
    check("u3 outputs after async reset", {7'd0, mem_rd3, mem_addr3, stall3, rf_we3, ptr3, di3, ovf3}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("u1 no write after abort c%0d", k), {30'd0, rf_we1, stall1}, 0);
      check($sformatf("u3 no write after abort c%0d", k), {30'd0, rf_we3, stall3}, 0);
    end
    apply(mk(1, 1, 1, 5'd6, 8'h40, 0, 0, 1, 0), "post-reset load");
    apply(mk(1, 0, 1, 5'd3, 8'hA7, 0, 0, 1, 0), "post-reset op");

    wait_idle();
    repeat (3) @(negedge clk);
    check("u1 expected writes drained", q1.size(), 0);
    check("u3 expected writes drained", q3.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
